// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback arbiter and its FIFO.
package wb_pkg;

    localparam int FIFO_DEPTH_DEF = 4;
    localparam int IDX_W_DEF      = 5;
    localparam int DATA_W_DEF     = 32;

    typedef struct packed {
        logic                  valid;
        logic                  killed;
        logic [IDX_W_DEF-1:0]  idx;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

    // An occupied, still-live entry destined for register q.
    function automatic logic entry_live_match(input wb_entry_t e, input logic [IDX_W_DEF-1:0] q);
        return e.valid && !e.killed && (e.idx == q);
    endfunction

endpackage

// File: rtl/sys_defs.vh
// System-wide defines shared by the pipeline blocks.
// ZERO_REG is the hard-wired zero register; results aimed at it are discarded.
`ifndef SYS_DEFS_VH
`define SYS_DEFS_VH

`define ZERO_REG 5'd0

`endif

// File: rtl/wb_fifo.sv
// In-order FIFO for buffered long-latency results, with kill-by-index.
// With WB_FWD_EN defined, all entries are exposed in age order (head first).
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH_DEF,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  wb_entry_t            push_entry,
    input  logic                 pop,
    input  logic                 kill_en,
    input  logic [IDX_W_DEF-1:0] kill_idx,
    output wb_entry_t            head,
    output logic [CNT_W-1:0]     cnt
`ifdef WB_FWD_EN
    ,
    output wb_entry_t            entries [DEPTH]
`endif
);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Kill is applied before the push so a same-cycle push keeps its own killed flag.
    always_comb begin
        mem_d = mem_q;
        if (kill_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_live_match(mem_q[i], kill_idx)) begin
                    mem_d[i].killed = 1'b1;
                end
            end
        end
        if (pop) begin
            mem_d[rd_ptr_q] = '0;
        end
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
        end
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign cnt  = cnt_q;

`ifdef WB_FWD_EN
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            entries[k] = mem_q[rd_ptr_q + PTR_W'(k)];
        end
    end
`endif

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (cnt_q == CNT_W'(DEPTH))));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && (cnt_q == '0)));
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU and long-latency result paths onto the single
// register-file write port. Optional macro WB_FWD_EN adds two pending-write forwarding lookups.
`include "sys_defs.vh"

module wb_arbiter
    import wb_pkg::*;
#(
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter  int DATA_W     = DATA_W_DEF,
    parameter  int IDX_W      = IDX_W_DEF,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [IDX_W-1:0]  alu_idx,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [IDX_W-1:0]  lsu_idx,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_idx,
    output logic [DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]  fifo_cnt
`ifdef WB_FWD_EN
    ,
    input  logic [IDX_W-1:0]  fwd_a_idx,
    input  logic [IDX_W-1:0]  fwd_b_idx,
    output logic              fwd_a_hit,
    output logic              fwd_b_hit,
    output logic [DATA_W-1:0] fwd_a_data,
    output logic [DATA_W-1:0] fwd_b_data
`endif
);

    logic              alu_fire, lsu_fire, lsu_keep, bypass;
    logic              fifo_push, fifo_pop;
    wb_entry_t         push_entry, head;
    logic [CNT_W-1:0]  cnt;
    logic              wr_en_q, wr_en_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    // Ready looks only at the registered count, never at a same-cycle pop.
    assign lsu_ready = rst_n && (cnt < CNT_W'(FIFO_DEPTH));
    assign lsu_fire  = lsu_valid && lsu_ready;
    assign alu_fire  = alu_valid && (alu_idx != IDX_W'(`ZERO_REG));
    assign lsu_keep  = lsu_fire && (lsu_idx != IDX_W'(`ZERO_REG));

    always_comb begin
        wr_en_d   = 1'b0;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        fifo_pop  = 1'b0;
        bypass    = 1'b0;
        if (alu_fire) begin
            wr_en_d   = 1'b1;
            wr_idx_d  = alu_idx;
            wr_data_d = alu_data;
        end else if (cnt != '0) begin
            fifo_pop = 1'b1;
            if (head.valid && !head.killed) begin
                wr_en_d   = 1'b1;
                wr_idx_d  = head.idx;
                wr_data_d = head.data;
            end
        end else if (lsu_keep) begin
            bypass    = 1'b1;
            wr_en_d   = 1'b1;
            wr_idx_d  = lsu_idx;
            wr_data_d = lsu_data;
        end
    end

    // A same-cycle ALU write to the same register is younger, so the push arrives pre-killed.
    always_comb begin
        fifo_push         = lsu_keep && !bypass;
        push_entry.valid  = 1'b1;
        push_entry.killed = alu_fire && (alu_idx == lsu_idx);
        push_entry.idx    = lsu_idx;
        push_entry.data   = lsu_data;
    end

`ifdef WB_FWD_EN
    wb_entry_t fwd_entries [FIFO_DEPTH];
`endif

    wb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_entry(push_entry),
        .pop       (fifo_pop),
        .kill_en   (alu_fire),
        .kill_idx  (alu_idx),
        .head      (head),
        .cnt       (cnt)
`ifdef WB_FWD_EN
        ,
        .entries   (fwd_entries)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_idx   = wr_idx_q;
    assign wr_data  = wr_data_q;
    assign fifo_cnt = cnt;

`ifdef WB_FWD_EN
    // Scan oldest to youngest so the last match (youngest pending write) wins.
    function automatic logic [DATA_W:0] fwd_lookup(input logic [IDX_W-1:0] q);
        logic [DATA_W:0] res;
        res = '0;
        if (q != IDX_W'(`ZERO_REG)) begin
            if (wr_en_q && (wr_idx_q == q)) begin
                res = {1'b1, wr_data_q};
            end
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                if (entry_live_match(fwd_entries[k], q)) begin
                    res = {1'b1, fwd_entries[k].data};
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        {fwd_a_hit, fwd_a_data} = fwd_lookup(fwd_a_idx);
        {fwd_b_hit, fwd_b_data} = fwd_lookup(fwd_b_idx);
    end
`endif

`ifndef SYNTHESIS
    a_wr_idx_known: assert property (@(posedge clk) disable iff (!rst_n)
        wr_en_q |-> !$isunknown(wr_idx_q));
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized scoreboard bench for wb_arbiter against a queue-based reference model.
// Forwarding checks are compiled in when WB_FWD_EN is defined.
module tb_wb_arbiter;

    localparam int DEPTH  = 4;
    localparam int IDX_W  = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              alu_valid;
    logic [IDX_W-1:0]  alu_idx;
    logic [DATA_W-1:0] alu_data;
    logic              lsu_valid;
    logic              lsu_ready;
    logic [IDX_W-1:0]  lsu_idx;
    logic [DATA_W-1:0] lsu_data;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [CNT_W-1:0]  fifo_cnt;
`ifdef WB_FWD_EN
    logic [IDX_W-1:0]  fwd_a_idx, fwd_b_idx;
    logic              fwd_a_hit, fwd_b_hit;
    logic [DATA_W-1:0] fwd_a_data, fwd_b_data;
`endif

    wb_arbiter #(
        .FIFO_DEPTH(DEPTH),
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .alu_valid(alu_valid),
        .alu_idx  (alu_idx),
        .alu_data (alu_data),
        .lsu_valid(lsu_valid),
        .lsu_ready(lsu_ready),
        .lsu_idx  (lsu_idx),
        .lsu_data (lsu_data),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .fifo_cnt (fifo_cnt)
`ifdef WB_FWD_EN
        ,
        .fwd_a_idx (fwd_a_idx),
        .fwd_b_idx (fwd_b_idx),
        .fwd_a_hit (fwd_a_hit),
        .fwd_b_hit (fwd_b_hit),
        .fwd_a_data(fwd_a_data),
        .fwd_b_data(fwd_b_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        bit                killed;
    } pend_t;

    typedef struct {
        bit                en;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        int                cnt;
`ifdef WB_FWD_EN
        bit                faHit;
        logic [DATA_W-1:0] faData;
        bit                fbHit;
        logic [DATA_W-1:0] fbData;
`endif
    } exp_t;

    pend_t             pend[$];
    exp_t              expQ[$];
    bit                lastEn;
    logic [IDX_W-1:0]  lastIdx;
    logic [DATA_W-1:0] lastData;
    int                vectors = 0;
    int                miscompares = 0;
    bit                acc;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Youngest pending write to q: the last register-file write, then queue front to back.
    function automatic logic [DATA_W:0] fwdModel(input logic [IDX_W-1:0] q);
        logic [DATA_W:0] r;
        r = '0;
        if (q != 0) begin
            if (lastEn && lastIdx == q) r = {1'b1, lastData};
            foreach (pend[i]) begin
                if (!pend[i].killed && pend[i].idx == q) r = {1'b1, pend[i].data};
            end
        end
        return r;
    endfunction

    task automatic modelStep(input bit av, input logic [IDX_W-1:0] ai, input logic [DATA_W-1:0] ad,
                             input bit lv, input logic [IDX_W-1:0] li, input logic [DATA_W-1:0] ld,
                             input logic [IDX_W-1:0] fa, input logic [IDX_W-1:0] fb,
                             output bit accepted);
        exp_t  e;
        pend_t p;
        bit    aluOk, lsuOk;
        accepted = lv && (pend.size() < DEPTH);
        aluOk    = av && (ai != 0);
        lsuOk    = accepted && (li != 0);
        e.en = 0; e.idx = '0; e.data = '0;
        if (aluOk) begin
            e.en = 1; e.idx = ai; e.data = ad;
            foreach (pend[i]) if (pend[i].idx == ai) pend[i].killed = 1;
        end else if (pend.size() > 0) begin
            p = pend.pop_front();
            if (!p.killed) begin
                e.en = 1; e.idx = p.idx; e.data = p.data;
            end
        end else if (lsuOk) begin
            e.en = 1; e.idx = li; e.data = ld;
            lsuOk = 0;
        end
        if (lsuOk) pend.push_back('{idx: li, data: ld, killed: (aluOk && ai == li)});
        lastEn = e.en;
        if (e.en) begin
            lastIdx = e.idx;
            lastData = e.data;
        end
        e.cnt = pend.size();
`ifdef WB_FWD_EN
        {e.faHit, e.faData} = fwdModel(fa);
        {e.fbHit, e.fbData} = fwdModel(fb);
`endif
        expQ.push_back(e);
    endtask

    // Called at a falling edge: drive one cycle of inputs, record the expectation, advance.
    task automatic applyStimulus(input bit av, input logic [IDX_W-1:0] ai, input logic [DATA_W-1:0] ad,
                                 input bit lv, input logic [IDX_W-1:0] li, input logic [DATA_W-1:0] ld,
                                 input logic [IDX_W-1:0] fa, input logic [IDX_W-1:0] fb,
                                 output bit accepted);
        alu_valid = av; alu_idx = ai; alu_data = ad;
        lsu_valid = lv; lsu_idx = li; lsu_data = ld;
`ifdef WB_FWD_EN
        fwd_a_idx = fa; fwd_b_idx = fb;
`endif
        modelStep(av, ai, ad, lv, li, ld, fa, fb, accepted);
        @(negedge clk);
    endtask

    task automatic idle();
        bit a;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, a);
    endtask

    task automatic resetModel();
        pend.delete();
        expQ.delete();
        lastEn = 0;
    endtask

    // Monitor: one expectation per clock edge while out of reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b1 && expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("wr_en", wr_en, e.en);
                if (e.en) begin
                    checkOutput("wr_idx", wr_idx, e.idx);
                    checkOutput("wr_data", wr_data, e.data);
                end
                checkOutput("fifo_cnt", fifo_cnt, e.cnt);
                checkOutput("lsu_ready", lsu_ready, (e.cnt < DEPTH));
`ifdef WB_FWD_EN
                checkOutput("fwd_a_hit", fwd_a_hit, e.faHit);
                if (e.faHit) checkOutput("fwd_a_data", fwd_a_data, e.faData);
                checkOutput("fwd_b_hit", fwd_b_hit, e.fbHit);
                if (e.fbHit) checkOutput("fwd_b_data", fwd_b_data, e.fbData);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int got;
        int aluPct;
        rst_n = 1'b0;
        alu_valid = 0; alu_idx = 0; alu_data = 0;
        lsu_valid = 0; lsu_idx = 0; lsu_data = 0;
`ifdef WB_FWD_EN
        fwd_a_idx = 0; fwd_b_idx = 0;
`endif
        resetModel();
        repeat (2) @(negedge clk);
        checkOutput("rst_wr_en", wr_en, 0);
        checkOutput("rst_wr_idx", wr_idx, 0);
        checkOutput("rst_wr_data", wr_data, 0);
        checkOutput("rst_fifo_cnt", fifo_cnt, 0);
        checkOutput("rst_lsu_ready", lsu_ready, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_ready", lsu_ready, 1);

        $display("[TB] ALU write, latency 1");
        applyStimulus(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, acc);
        checkOutput("alu_wr_en", wr_en, 1);
        checkOutput("alu_wr_idx", wr_idx, 3);
        checkOutput("alu_wr_data", wr_data, 32'hDEADBEEF);
        checkOutput("alu_cnt", fifo_cnt, 0);

        $display("[TB] long-latency bypass");
        applyStimulus(0, 0, 0, 1, 7, 32'h12, 0, 0, acc);
        checkOutput("byp_wr_en", wr_en, 1);
        checkOutput("byp_wr_idx", wr_idx, 7);
        checkOutput("byp_cnt", fifo_cnt, 0);

        $display("[TB] fill FIFO under ALU pressure");
        got = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, IDX_W'(20 + i), 32'h1000 + i, (got < 4), IDX_W'(8 + got),
                          32'h100 + got, 0, 0, acc);
            if (acc) got++;
        end
        checkOutput("fill_cnt", fifo_cnt, 4);
        checkOutput("fill_ready", lsu_ready, 0);
        for (int i = 0; i < 4; i++) begin
            idle();
            checkOutput("drain_wr_en", wr_en, 1);
            checkOutput("drain_wr_idx", wr_idx, 8 + i);
        end
        checkOutput("drain_ready", lsu_ready, 1);

        $display("[TB] younger ALU write kills buffered entry");
        applyStimulus(1, 1, 32'h11, 1, 5, 32'hAA, 0, 0, acc);
        applyStimulus(1, 5, 32'hBB, 0, 0, 0, 0, 0, acc);
        checkOutput("kill_wr_data", wr_data, 32'hBB);
        checkOutput("kill_cnt", fifo_cnt, 1);
        idle();
        checkOutput("killed_pop_wr_en", wr_en, 0);
        checkOutput("killed_pop_cnt", fifo_cnt, 0);

        $display("[TB] zero register on both paths");
        applyStimulus(1, 0, 32'h55, 1, 0, 32'h66, 0, 0, acc);
        checkOutput("zero_wr_en", wr_en, 0);
        checkOutput("zero_cnt", fifo_cnt, 0);

        $display("[TB] reset with pending entries");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, IDX_W'(12 + i), 32'h200 + i, 1, IDX_W'(16 + i), 32'h300 + i, 0, 0, acc);
        end
        checkOutput("pre_rst_cnt", fifo_cnt, 3);
        rst_n = 1'b0;
        resetModel();
        #1;
        checkOutput("midrst_wr_en", wr_en, 0);
        checkOutput("midrst_cnt", fifo_cnt, 0);
        checkOutput("midrst_ready", lsu_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            idle();
            checkOutput("after_rst_wr_en", wr_en, 0);
        end

`ifdef WB_FWD_EN
        $display("[TB] forwarding youngest match");
        applyStimulus(1, 1, 32'h7, 1, 4, 32'h1, 4, 0, acc);
        applyStimulus(1, 2, 32'h8, 1, 4, 32'h2, 4, 0, acc);
        checkOutput("fwd_dir_hit", fwd_a_hit, 1);
        checkOutput("fwd_dir_data", fwd_a_data, 32'h2);
        checkOutput("fwd_dir_b_miss", fwd_b_hit, 0);
        idle();
        idle();
`endif

        $display("[TB] randomized traffic");
        for (int n = 0; n < 3000; n++) begin
            aluPct = ((n / 40) % 2 == 1) ? 90 : 30;
            applyStimulus(($urandom_range(0, 99) < aluPct), IDX_W'($urandom_range(0, 7)), $urandom,
                          ($urandom_range(0, 99) < 60), IDX_W'($urandom_range(0, 7)), $urandom,
                          IDX_W'($urandom_range(0, 7)), IDX_W'($urandom_range(0, 7)), acc);
        end
        repeat (6) idle();
        checkOutput("scoreboard_drained", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
